// File: rtl/prog_sequencer_if.sv
// Instruction-memory access bundle: loader byte stream, CPU fetch port and
// the shared instruction memory write/address lines.
interface prog_sequencer_if #(
    parameter int AW = 4,
    parameter int DW = 8
);
    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic          ld_last;
    logic          ld_ready;
    logic          fetch_req;
    logic [AW-1:0] fetch_addr;
    logic          fetch_gnt;
    logic [AW-1:0] imem_addr;
    logic          imem_we;
    logic [DW-1:0] imem_din;

    modport slave (
        input  ld_valid, ld_data, ld_last, fetch_req, fetch_addr,
        output ld_ready, fetch_gnt, imem_addr, imem_we, imem_din
    );

    modport master (
        output ld_valid, ld_data, ld_last, fetch_req, fetch_addr,
        input  ld_ready, fetch_gnt, imem_addr, imem_we, imem_din
    );
endinterface

// File: rtl/prog_sequencer.sv
// Shares the instruction memory port between the program loader and the CPU
// fetch stage, and gates CPU execution with run / halt / single-step control.
module prog_sequencer #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_start,
    input  logic          run_req,
    input  logic          halt_req,
    input  logic          step_req,
    input  logic          instr_done,
    prog_sequencer_if.slave bus,
    output logic          cpu_en,
    output logic [AW:0]   load_count,
    output logic [1:0]    state_o,
    output logic          err_ovf
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_STEP = 2'd3
    } state_t;

    localparam logic [AW-1:0] WPTR_MAX = {AW{1'b1}};

    state_t        state_r;
    logic [AW-1:0] wptr_r;
    logic [AW:0]   load_count_r;
    logic          err_ovf_r;
    logic          halt_pend_r;
    logic          load_pend_r;
    logic          ld_ready_r;
    logic          cpu_en_r;

    logic          accept_s;
    logic          exec_s;
    logic [AW-1:0] imem_addr_s;
    logic          imem_we_s;
    logic [DW-1:0] imem_din_s;
    logic          fetch_gnt_s;

    assign accept_s = bus.ld_valid & ld_ready_r;
    assign exec_s   = (state_r == ST_RUN) || (state_r == ST_STEP);

    // Memory port mux: CPU owns the address while executing, loader otherwise.
    always_comb begin
        imem_addr_s = wptr_r;
        imem_we_s   = 1'b0;
        imem_din_s  = {DW{1'b0}};
        fetch_gnt_s = 1'b0;
        if (exec_s) begin
            imem_addr_s = bus.fetch_addr;
            fetch_gnt_s = bus.fetch_req;
        end else begin
            imem_we_s  = accept_s;
            imem_din_s = ld_ready_r ? bus.ld_data : {DW{1'b0}};
        end
    end

    // Sequencer FSM with its pointers, pending requests and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            wptr_r       <= {AW{1'b0}};
            load_count_r <= {(AW+1){1'b0}};
            err_ovf_r    <= 1'b0;
            halt_pend_r  <= 1'b0;
            load_pend_r  <= 1'b0;
            ld_ready_r   <= 1'b0;
            cpu_en_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (load_start) begin
                        state_r      <= ST_LOAD;
                        wptr_r       <= {AW{1'b0}};
                        load_count_r <= {(AW+1){1'b0}};
                        err_ovf_r    <= 1'b0;
                        ld_ready_r   <= 1'b1;
                    end else if (run_req) begin
                        state_r     <= ST_RUN;
                        cpu_en_r    <= 1'b1;
                        halt_pend_r <= 1'b0;
                        load_pend_r <= 1'b0;
                    end else if (step_req) begin
                        state_r     <= ST_STEP;
                        cpu_en_r    <= 1'b1;
                        halt_pend_r <= 1'b0;
                        load_pend_r <= 1'b0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    if (accept_s) begin
                        // The pointer saturates: an upload ends at the last slot at the latest.
                        wptr_r       <= (wptr_r == WPTR_MAX) ? wptr_r
                                        : wptr_r + {{(AW-1){1'b0}}, 1'b1};
                        load_count_r <= load_count_r + {{AW{1'b0}}, 1'b1};
                        if (bus.ld_last) begin
                            state_r    <= ST_IDLE;
                            ld_ready_r <= 1'b0;
                        end else if (wptr_r == WPTR_MAX) begin
                            state_r    <= ST_IDLE;
                            ld_ready_r <= 1'b0;
                            err_ovf_r  <= 1'b1;
                        end else begin
                            state_r <= ST_LOAD;
                        end
                    end else begin
                        state_r <= ST_LOAD;
                    end
                end
                ST_RUN, ST_STEP: begin
                    if (instr_done && (load_pend_r || load_start)) begin
                        state_r      <= ST_LOAD;
                        wptr_r       <= {AW{1'b0}};
                        load_count_r <= {(AW+1){1'b0}};
                        err_ovf_r    <= 1'b0;
                        ld_ready_r   <= 1'b1;
                        cpu_en_r     <= 1'b0;
                        halt_pend_r  <= 1'b0;
                        load_pend_r  <= 1'b0;
                    end else if (instr_done && ((state_r == ST_STEP) || halt_pend_r || halt_req)) begin
                        state_r     <= ST_IDLE;
                        cpu_en_r    <= 1'b0;
                        halt_pend_r <= 1'b0;
                        load_pend_r <= 1'b0;
                    end else begin
                        // Halt only matters in free-run; a step already stops by itself.
                        halt_pend_r <= halt_pend_r | (halt_req && (state_r == ST_RUN));
                        load_pend_r <= load_pend_r | load_start;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    ld_ready_r <= 1'b0;
                    cpu_en_r   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ld_ready  = ld_ready_r;
    assign bus.fetch_gnt = fetch_gnt_s;
    assign bus.imem_addr = imem_addr_s;
    assign bus.imem_we   = imem_we_s;
    assign bus.imem_din  = imem_din_s;
    assign cpu_en        = cpu_en_r;
    assign load_count    = load_count_r;
    assign state_o       = state_r;
    assign err_ovf       = err_ovf_r;
endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: vector table for the basic upload,
// write scoreboard for every memory write, hand sequences for control timing.
module tb_prog_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic       load_start, run_req, halt_req, step_req, instr_done;
    logic       cpu_en, err_ovf;
    logic [4:0] load_count;
    logic [1:0] state_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       last;
        logic       exp_rdy;
        logic       exp_we;
        logic [3:0] exp_addr;
    } vec_t;

    typedef struct packed {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    vec_t vecs[7];
    wr_t  sb_q[$];

    prog_sequencer_if #(.AW(4), .DW(8)) bus();

    prog_sequencer #(.AW(4), .DW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .run_req    (run_req),
        .halt_req   (halt_req),
        .step_req   (step_req),
        .instr_done (instr_done),
        .bus        (bus),
        .cpu_en     (cpu_en),
        .load_count (load_count),
        .state_o    (state_o),
        .err_ovf    (err_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write scoreboard and port-sharing invariant, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (bus.imem_we === 1'b1 && bus.fetch_gnt === 1'b1) begin
                total++;
                bad++;
                $display("FAIL we_gnt_overlap: imem_we=1 fetch_gnt=1 required not both");
            end
            if (bus.imem_we === 1'b1) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected_write: addr=%0d data=%0h required no write",
                             bus.imem_addr, bus.imem_din);
                end else begin
                    wr_t e;
                    e = sb_q.pop_front();
                    chk("sb_addr", 32'(bus.imem_addr), 32'(e.a));
                    chk("sb_data", 32'(bus.imem_din), 32'(e.d));
                end
            end
        end
    end

    initial begin
        vecs[0] = '{1'b1, 8'h41, 1'b0, 1'b1, 1'b1, 4'd0};
        vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd1};
        vecs[2] = '{1'b1, 8'h06, 1'b0, 1'b1, 1'b1, 4'd1};
        vecs[3] = '{1'b1, 8'h8B, 1'b0, 1'b1, 1'b1, 4'd2};
        vecs[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd3};
        vecs[5] = '{1'b1, 8'hC2, 1'b0, 1'b1, 1'b1, 4'd3};
        vecs[6] = '{1'b1, 8'h1D, 1'b1, 1'b1, 1'b1, 4'd4};

        rst = 1'b0;
        load_start = 1'b0; run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0;
        instr_done = 1'b0;
        bus.ld_valid = 1'b0; bus.ld_data = 8'h00; bus.ld_last = 1'b0;
        bus.fetch_req = 1'b0; bus.fetch_addr = 4'd0;

        // Reset
        repeat (3) tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_cpu_en", 32'(cpu_en), 32'd0);
        chk("rst_ld_ready", 32'(bus.ld_ready), 32'd0);
        chk("rst_imem_we", 32'(bus.imem_we), 32'd0);
        chk("rst_load_count", 32'(load_count), 32'd0);
        chk("rst_err_ovf", 32'(err_ovf), 32'd0);

        // Five-word upload with gaps in ld_valid
        tick(); load_start = 1'b1;
        tick(); load_start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus.ld_valid = vecs[i].v;
            bus.ld_data  = vecs[i].d;
            bus.ld_last  = vecs[i].last;
            if (vecs[i].exp_we) sb_q.push_back('{a: vecs[i].exp_addr, d: vecs[i].d});
            @(negedge clk);
            chk("up_state", 32'(state_o), 32'd1);
            chk("up_ld_ready", 32'(bus.ld_ready), 32'(vecs[i].exp_rdy));
            chk("up_imem_we", 32'(bus.imem_we), 32'(vecs[i].exp_we));
            chk("up_imem_addr", 32'(bus.imem_addr), 32'(vecs[i].exp_addr));
            tick();
        end
        bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
        @(negedge clk);
        chk("up_end_state", 32'(state_o), 32'd0);
        chk("up_load_count", 32'(load_count), 32'd5);
        chk("up_err_ovf", 32'(err_ovf), 32'd0);
        chk("up_end_ld_ready", 32'(bus.ld_ready), 32'd0);

        // Run, then halt two cycles before the end of the instruction
        tick(); run_req = 1'b1;
        tick(); run_req = 1'b0; bus.fetch_req = 1'b1; bus.fetch_addr = 4'd3;
        @(negedge clk);
        chk("run_state", 32'(state_o), 32'd2);
        chk("run_cpu_en", 32'(cpu_en), 32'd1);
        chk("run_fetch_gnt", 32'(bus.fetch_gnt), 32'd1);
        chk("run_imem_addr", 32'(bus.imem_addr), 32'd3);
        chk("run_imem_we", 32'(bus.imem_we), 32'd0);
        tick(); halt_req = 1'b1;
        tick(); halt_req = 1'b0;
        @(negedge clk);
        chk("halt_pend_cpu_en", 32'(cpu_en), 32'd1);
        chk("halt_pend_state", 32'(state_o), 32'd2);
        tick(); instr_done = 1'b1;
        @(negedge clk);
        chk("halt_done_cpu_en", 32'(cpu_en), 32'd1);
        tick(); instr_done = 1'b0;
        @(negedge clk);
        chk("halt_state", 32'(state_o), 32'd0);
        chk("halt_cpu_en", 32'(cpu_en), 32'd0);
        chk("idle_fetch_gnt", 32'(bus.fetch_gnt), 32'd0);
        chk("idle_imem_addr", 32'(bus.imem_addr), 32'd5);

        // Single step with a redundant second step request
        tick(); bus.fetch_req = 1'b0; step_req = 1'b1;
        tick(); step_req = 1'b0;
        @(negedge clk);
        chk("step_state", 32'(state_o), 32'd3);
        chk("step_cpu_en", 32'(cpu_en), 32'd1);
        tick(); step_req = 1'b1;
        tick(); step_req = 1'b0;
        @(negedge clk);
        chk("step_ignore_state", 32'(state_o), 32'd3);
        tick(); instr_done = 1'b1;
        tick(); instr_done = 1'b0;
        @(negedge clk);
        chk("step_end_state", 32'(state_o), 32'd0);
        chk("step_end_cpu_en", 32'(cpu_en), 32'd0);
        tick(); instr_done = 1'b1;
        tick(); instr_done = 1'b0;
        tick();
        @(negedge clk);
        chk("step_stays_idle", 32'(state_o), 32'd0);

        // Reload requested mid-instruction
        tick(); run_req = 1'b1;
        tick(); run_req = 1'b0;
        tick(); load_start = 1'b1;
        tick(); load_start = 1'b0;
        @(negedge clk);
        chk("reload_wait_state", 32'(state_o), 32'd2);
        chk("reload_wait_count", 32'(load_count), 32'd5);
        tick(); instr_done = 1'b1;
        tick(); instr_done = 1'b0;
        @(negedge clk);
        chk("reload_state", 32'(state_o), 32'd1);
        chk("reload_count", 32'(load_count), 32'd0);
        chk("reload_cpu_en", 32'(cpu_en), 32'd0);
        chk("reload_imem_addr", 32'(bus.imem_addr), 32'd0);
        bus.ld_valid = 1'b1; bus.ld_data = 8'hAA; bus.ld_last = 1'b1;
        sb_q.push_back('{a: 4'd0, d: 8'hAA});
        tick(); bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
        @(negedge clk);
        chk("reload_end_state", 32'(state_o), 32'd0);
        chk("reload_end_count", 32'(load_count), 32'd1);

        // Overflow: 17 words, no ld_last; load_start outranks run_req
        tick(); load_start = 1'b1; run_req = 1'b1;
        tick(); load_start = 1'b0; run_req = 1'b0;
        for (int k = 0; k < 17; k++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = 8'(8'h10 + k);
            bus.ld_last  = 1'b0;
            if (k < 16) sb_q.push_back('{a: 4'(k), d: 8'(8'h10 + k)});
            @(negedge clk);
            chk("ovf_ld_ready", 32'(bus.ld_ready), (k < 16) ? 32'd1 : 32'd0);
            chk("ovf_state", 32'(state_o), (k < 16) ? 32'd1 : 32'd0);
            tick();
        end
        bus.ld_valid = 1'b0;
        @(negedge clk);
        chk("ovf_err", 32'(err_ovf), 32'd1);
        chk("ovf_count", 32'(load_count), 32'd16);

        // Exactly DEPTH words with ld_last on the final one
        tick(); load_start = 1'b1;
        tick(); load_start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = 8'(8'hE0 + k);
            bus.ld_last  = (k == 15);
            sb_q.push_back('{a: 4'(k), d: 8'(8'hE0 + k)});
            @(negedge clk);
            chk("full_ld_ready", 32'(bus.ld_ready), 32'd1);
            tick();
        end
        bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
        @(negedge clk);
        chk("full_err", 32'(err_ovf), 32'd0);
        chk("full_count", 32'(load_count), 32'd16);
        chk("full_state", 32'(state_o), 32'd0);

        tick();
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
- Owns the 16-entry x 8-bit instruction memory port. Shares it between an external byte-stream program loader and the CPU fetch stage, and gates CPU execution through run, halt and single-step control.
- Sits between the board-level upload interface and the core.
- Replaces direct drive of the instruction memory's we/addr/d_in by top-level pins.

Parameters:
- AW, 4, instruction memory address width; DEPTH = 2**AW.
- DW, 8, instruction word width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- load_start  in  1  one-cycle pulse; requests a program upload.
- ld_valid  in  1  loader byte valid.
- ld_data  in  DW  loader instruction word.
- ld_last  in  1  qualifies the final word of an upload.
- ld_ready  out  1  sequencer accepts the loader word this cycle.
- run_req  in  1  pulse; enter free-running execution.
- halt_req  in  1  pulse; stop execution.
- step_req  in  1  pulse; execute exactly one instruction, then halt.
- fetch_req  in  1  CPU requests an instruction read.
- fetch_addr  in  AW  CPU program counter.
- fetch_gnt  out  1  fetch request granted this cycle.
- instr_done  in  1  CPU pulse at end of its finish-cycle state.
- imem_addr  out  AW  instruction memory address.
- imem_we  out  1  instruction memory write enable.
- imem_din  out  DW  instruction memory write data.
- cpu_en  out  1  CPU clock-enable / state-advance permit.
- load_count  out  AW+1  words written by the last upload (0..DEPTH).
- state_o  out  2  current state: 0 IDLE, 1 LOAD, 2 RUN, 3 STEP.
- err_ovf  out  1  sticky; upload exceeded DEPTH words.

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - state IDLE; all outputs 0 (ld_ready, fetch_gnt, imem_we, cpu_en, load_count, err_ovf).
  - Internal write pointer 0.
  - On rst release, nothing changes until a request arrives.
- States:
  - IDLE: CPU halted (cpu_en=0); fetch_gnt=0; ld_ready=0.
    - load_start -> LOAD; clears wptr, load_count and err_ovf.
    - else run_req -> RUN.
    - else step_req -> STEP.
    - Priority is load_start > run_req > step_req.
  - LOAD: ld_ready=1; cpu_en=0; fetch_gnt=0.
    - Word accepted on ld_valid & ld_ready. Same cycle (combinational): imem_we=1, imem_addr=wptr, imem_din=ld_data.
    - wptr and load_count increment on each accept.
    - Accept with ld_last=1 -> IDLE.
    - Accept when wptr==DEPTH-1 without ld_last -> IDLE with err_ovf=1, after writing that word. Further words are not accepted (ld_ready=0 in IDLE).
    - Accept with ld_last=1 at wptr==DEPTH-1 -> IDLE, err_ovf stays 0; load_count=DEPTH.
    - halt_req, run_req, step_req and load_start are ignored in LOAD.
  - RUN: cpu_en=1; fetch_gnt=fetch_req, combinational; imem_addr=fetch_addr; imem_we=0.
    - halt_req -> IDLE at the next instr_done, not mid-instruction. The pending halt is latched until then.
    - load_start in RUN is also latched. It takes effect at the next instr_done: -> LOAD; wptr, load_count and err_ovf cleared.
    - Latched load outranks latched halt.
  - STEP: same as RUN, but the first instr_done -> IDLE.
    - Further step_req/run_req pulses are ignored while in STEP.
    - halt_req in STEP is redundant and ignored.
- Arbitration invariant: imem_we and fetch_gnt are never 1 in the same cycle. In IDLE and LOAD, fetch_addr has no effect on imem_addr; imem_addr shows wptr.
- Pointer arithmetic:
  - wptr is AW bits and never wraps within one upload; the overflow rule stops it.
  - load_count is AW+1 bits so DEPTH is representable.
- Simultaneous pulses in the same cycle in IDLE follow the priority above.
- instr_done seen outside RUN/STEP is ignored.
- Reset asserted mid-LOAD: the upload is aborted; memory contents already written are not cleared.
- state_o is registered and equals the current state encoding.

Test Plan:
- Reset then IDLE: drive rst=0 for 3 cycles, release -> state_o=0, cpu_en=0, ld_ready=0, imem_we=0, load_count=0.
- Upload of 5 words (0x41, 0x06, 0x8B, 0xC2, 0x1D, last on the 5th), with ld_valid toggling 1,0,1,1,0,1,1 -> imem_we pulses only on the accepts, at addresses 0..4. Ends in IDLE with load_count=5, err_ovf=0.
- Overflow: load_start, then 17 consecutive valid words with no ld_last -> 16 writes at addresses 0..15, state returns to IDLE after the 16th, err_ovf=1, load_count=16, 17th word never gets ld_ready.
- Run/halt timing: run_req; CPU issues fetch_req with fetch_addr=3; halt_req asserted 2 cycles before instr_done -> fetch_gnt=1 and imem_addr=3, cpu_en stays 1 until instr_done, then state_o=0 the next cycle.
- Single step: step_req from IDLE -> state_o=3, cpu_en=1. One instr_done -> IDLE. A second step_req issued during STEP is ignored (exactly one instr_done observed).
- Reload during RUN: load_start issued mid-instruction -> state stays RUN until instr_done, then LOAD with load_count=0. Assert imem_we and fetch_gnt are never simultaneously high across the whole test.
